// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one ALU and one unified memory port.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB); illegal
// words park the core in HALT until reset.
// Optional feature macro: CPU_JUMP_EN (adds opcode 0x02, J).
module multicycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  // Architectural and inter-phase holding registers
  logic [31:0] regs [32];
  logic [31:0] ir;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out;
  logic [31:0] mdr;

  // Decoded instruction fields
  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [4:0]         shamt;
  logic signed [31:0] imm_sext;
  logic [31:0]        pc_plus4;

  // Per-cycle control produced by the FSM
  logic        pc_we;
  logic [31:0] pc_nxt;
  logic        ir_we;
  logic        ab_we;
  logic        alu_we;
  logic [31:0] alu_val;
  logic        mdr_we;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_sext = signed'({{16{ir[15]}}, ir[15:0]});
  assign pc_plus4 = pc + 32'd4;
  assign halt     = (state == S_HALT);

  // Shared ALU for R-type operations; wrap-around arithmetic, signed compare for slt.
  function automatic logic [31:0] alu_rtype(input logic [5:0] fn,
                                            input logic signed [31:0] a,
                                            input logic signed [31:0] b,
                                            input logic [4:0] sh);
    logic [31:0] r;
    case (fn)
      F_ADD:   r = $unsigned(a + b);
      F_SUB:   r = $unsigned(a - b);
      F_AND:   r = $unsigned(a & b);
      F_OR:    r = $unsigned(a | b);
      F_SLT:   r = (a < b) ? 32'd1 : 32'd0;
      F_SLL:   r = $unsigned(b) << sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Legality of an opcode/funct pair; anything else sends the core to HALT.
  function automatic logic insn_legal(input logic [5:0] opc, input logic [5:0] fn);
    logic ok;
    case (opc)
      OP_RTYPE: ok = fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
`ifdef CPU_JUMP_EN
      OP_J:     ok = 1'b1;
`endif
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // FSM state and pc register; reset restarts at RESET_PC
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (pc_we) pc <= pc_nxt;
    end
  end

  // Next-state, memory port and datapath enables for the current phase
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc[ADDR_W+1:2];
    mem_wdata = '0;
    retire    = 1'b0;
    pc_we     = 1'b0;
    pc_nxt    = pc_plus4;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    alu_we    = 1'b0;
    alu_val   = '0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we     = 1'b1;
        state_nxt = insn_legal(op, funct) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            alu_we    = 1'b1;
            alu_val   = alu_rtype(funct, $signed(a_q), $signed(b_q), shamt);
            state_nxt = S_WB;
          end
          OP_ADDI: begin
            alu_we    = 1'b1;
            alu_val   = $unsigned($signed(a_q) + imm_sext);
            state_nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_we    = 1'b1;
            alu_val   = $unsigned($signed(a_q) + imm_sext);
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            pc_we     = 1'b1;
            pc_nxt    = (a_q == b_q) ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
`ifdef CPU_JUMP_EN
          OP_J: begin
            pc_we     = 1'b1;
            pc_nxt    = {pc_plus4[31:28], ir[25:0], 2'b00};
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
`endif
          default: state_nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = alu_out[ADDR_W+1:2];
        mem_we    = (op == OP_SW);
        mem_wdata = b_q;
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = (op == OP_RTYPE) ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr : alu_out;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    // Reset abandons any transfer in flight: no request, no commit, no retire.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      retire    = 1'b0;
      ir_we     = 1'b0;
      ab_we     = 1'b0;
      alu_we    = 1'b0;
      mdr_we    = 1'b0;
      rf_we     = 1'b0;
    end
  end

  // Inter-phase datapath registers; contents are don't-care until loaded
  always_ff @(posedge clk) begin
    if (ir_we)  ir      <= mem_rdata;
    if (ab_we) begin
      a_q <= regs[rs];
      b_q <= regs[rt];
    end
    if (alu_we) alu_out <= alu_val;
    if (mdr_we) mdr     <= mem_rdata;
  end

  // Register file: cleared on reset, $0 writes discarded so it always reads 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: directed scenarios plus random
// programs compared against an instruction-level reference interpreter.
module tb_multicycle_cpu;

  localparam int ADDR_W    = 10;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              mem_ready;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, pc;
  logic              retire, halt;

  logic              req40, we40;
  logic [ADDR_W-1:0] addr40;
  logic [31:0]       wdata40, rdata40, pc40;
  logic              retire40, halt40;

  logic [31:0] mem [MEM_WORDS];
  assign mem_rdata = mem[mem_addr];
  assign rdata40   = mem[addr40];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_pc;

  multicycle_cpu #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .halt(halt));

  multicycle_cpu #(.RESET_PC(32'h0000_0040), .ADDR_W(ADDR_W)) dut40 (
    .clk(clk), .reset(reset), .mem_req(req40), .mem_we(we40), .mem_addr(addr40),
    .mem_wdata(wdata40), .mem_rdata(rdata40), .mem_ready(1'b1),
    .pc(pc40), .retire(retire40), .halt(halt40));

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int base_cycles(input logic [31:0] ir);
    case (ir[31:26])
      6'h04, 6'h02: return 3;
      6'h23:        return 5;
      default:      return 4;
    endcase
  endfunction

  function automatic bit model_legal(input logic [31:0] ir);
    case (ir[31:26])
      6'h00: return ir[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      6'h08, 6'h23, 6'h2B, 6'h04: return 1'b1;
`ifdef CPU_JUMP_EN
      6'h02: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = mem[i];
    m_pc = 32'h0;
  endtask

  // Execute one whole instruction at the ISA level.
  task automatic model_step();
    logic [31:0] ir, a, b, imm, nxt, r, addr;
    ir   = m_mem[m_pc[ADDR_W+1:2]];
    a    = m_reg[ir[25:21]];
    b    = m_reg[ir[20:16]];
    imm  = {{16{ir[15]}}, ir[15:0]};
    nxt  = m_pc + 32'd4;
    addr = a + imm;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = b << ir[10:6];
        endcase
        if (ir[15:11] != 5'd0) m_reg[ir[15:11]] = r;
      end
      6'h08: if (ir[20:16] != 5'd0) m_reg[ir[20:16]] = a + imm;
      6'h23: if (ir[20:16] != 5'd0) m_reg[ir[20:16]] = m_mem[addr[ADDR_W+1:2]];
      6'h2B: m_mem[addr[ADDR_W+1:2]] = b;
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (imm << 2);
      6'h02: nxt = {nxt[31:28], ir[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  endtask

  // Advance one clock: drive inputs just after the edge, return at the falling edge.
  task automatic tick(input bit rdy, input bit rst);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    @(negedge clk);
    if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  endtask

  // Leaves reset asserted; the next tick releases it and is cycle 1.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_clear();
    apply_reset();
    checks++; if ({mem_req, mem_we, retire, halt} !== 4'b0000) begin failures++;
      $display("FAIL reset_ctrl got req/we/ret/halt=%b expected 0000", {mem_req, mem_we, retire, halt}); end
    checks++; if (mem_wdata !== 32'h0) begin failures++;
      $display("FAIL reset_wdata got %h expected 0", mem_wdata); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h expected 0", pc); end
    checks++; if ({req40, we40, retire40, halt40, wdata40} !== 36'h0) begin failures++;
      $display("FAIL reset40_outs got %b/%h expected all 0", {req40, we40, retire40, halt40}, wdata40); end
    checks++; if (pc40 !== 32'h40) begin failures++; $display("FAIL reset40_pc got %h expected 40", pc40); end
    tick(1'b1, 1'b0);
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h000}) begin failures++;
      $display("FAIL first_fetch got req=%b we=%b addr=%h expected 1 0 000", mem_req, mem_we, mem_addr); end
    checks++; if ({req40, we40, addr40} !== {1'b1, 1'b0, 10'h010}) begin failures++;
      $display("FAIL first_fetch40 got req=%b we=%b addr=%h expected 1 0 010", req40, we40, addr40); end
  endtask

  task automatic test_alu_store();
    int retires, st_cyc;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0] st_data;
    mem_clear();
    mem[0] = enc_i(8, 0, 1, 5);
    mem[1] = enc_i(8, 0, 2, -7);
    mem[2] = enc_r(1, 2, 3, 0, 'h20);
    mem[3] = enc_i('h2B, 0, 3, 8);
    mem[4] = HALT_WORD;
    apply_reset();
    retires = 0; st_cyc = -1; st_addr = '0; st_data = '0;
    for (int c = 1; c <= 24; c++) begin
      tick(1'b1, 1'b0);
      if (retire) retires++;
      if (mem_req && mem_we && mem_ready && st_cyc < 0) begin
        st_cyc = c; st_addr = mem_addr; st_data = mem_wdata;
      end
    end
    checks++; if (st_addr !== 10'd2) begin failures++; $display("FAIL sw_addr got %h expected 2", st_addr); end
    checks++; if (st_data !== 32'hFFFF_FFFE) begin failures++;
      $display("FAIL sw_data got %h expected fffffffe", st_data); end
    checks++; if (st_cyc != 16) begin failures++; $display("FAIL sw_cycle got %0d expected 16", st_cyc); end
    checks++; if (retires != 4) begin failures++; $display("FAIL retire_count got %0d expected 4", retires); end
    checks++; if ({halt, pc} !== {1'b1, 32'h10}) begin failures++;
      $display("FAIL alu_end_halt got halt=%b pc=%h expected 1 10", halt, pc); end
  endtask

  task automatic test_lw_stall();
    int first_ret, st_cyc;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0] st_data;
    mem_clear();
    mem[0] = enc_i('h23, 0, 4, 0);
    mem[1] = enc_i('h2B, 0, 4, 4);
    mem[2] = HALT_WORD;
    apply_reset();
    first_ret = -1; st_cyc = -1; st_addr = '0; st_data = '0;
    for (int c = 1; c <= 20; c++) begin
      tick(!(c >= 4 && c <= 6), 1'b0);
      if (c >= 4 && c <= 7) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'd0, 32'd0}) begin failures++;
          $display("FAIL lw_hold c=%0d got req=%b we=%b addr=%h wd=%h expected 1 0 000 0",
                   c, mem_req, mem_we, mem_addr, mem_wdata); end
      end
      if (retire && first_ret < 0) first_ret = c;
      if (mem_req && mem_we && mem_ready && st_cyc < 0) begin
        st_cyc = c; st_addr = mem_addr; st_data = mem_wdata;
      end
    end
    checks++; if (first_ret != 8) begin failures++; $display("FAIL lw_cycles got %0d expected 8", first_ret); end
    checks++; if ({st_addr, st_data} !== {10'd1, 32'h8C04_0000}) begin failures++;
      $display("FAIL lw_sw_data got addr=%h data=%h expected 001 8c040000", st_addr, st_data); end
    checks++; if (st_cyc != 12) begin failures++; $display("FAIL lw_sw_cycle got %0d expected 12", st_cyc); end
  endtask

  task automatic test_branch();
    int rets;
    mem_clear();
    mem[0] = enc_i(4, 0, 0, 7);
    mem[8] = enc_i(4, 0, 0, -1);
    apply_reset();
    rets = 0;
    for (int c = 1; c <= 15; c++) begin
      tick(1'b1, 1'b0);
      if (c == 4) begin
        checks++; if ({mem_req, mem_addr} !== {1'b1, 10'd8}) begin failures++;
          $display("FAIL beq_target got req=%b addr=%h expected 1 008", mem_req, mem_addr); end
      end
      if (retire) begin
        rets++;
        checks++;
        if ((c % 3 != 0) || (pc !== ((c == 3) ? 32'h0 : 32'h20))) begin failures++;
          $display("FAIL beq_loop got retire at c=%0d pc=%h expected multiple of 3 and pc %h",
                   c, pc, (c == 3) ? 32'h0 : 32'h20); end
      end
    end
    checks++; if (rets != 5) begin failures++; $display("FAIL beq_rets got %0d expected 5", rets); end
    mem_clear();
    mem[0] = enc_i(8, 0, 1, 1);
    mem[1] = enc_i(4, 1, 2, 5);
    mem[2] = HALT_WORD;
    apply_reset();
    for (int c = 1; c <= 8; c++) begin
      tick(1'b1, 1'b0);
      if (c == 7) begin
        checks++; if ({retire, pc} !== {1'b1, 32'h4}) begin failures++;
          $display("FAIL bne_retire got retire=%b pc=%h expected 1 4", retire, pc); end
      end
    end
    checks++; if ({mem_req, mem_addr} !== {1'b1, 10'd2}) begin failures++;
      $display("FAIL bne_fallthru got req=%b addr=%h expected 1 002", mem_req, mem_addr); end
  endtask

  task automatic test_halt();
    mem_clear();
    mem[0] = HALT_WORD;
    apply_reset();
    for (int c = 1; c <= 8; c++) begin
      tick(1'b1, 1'b0);
      if (c == 2) begin
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_early got %b expected 0", halt); end
      end
      if (c >= 3) begin
        checks++;
        if ({halt, mem_req, retire, pc} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin failures++;
          $display("FAIL halt_hold c=%0d got halt=%b req=%b ret=%b pc=%h expected 1 0 0 0",
                   c, halt, mem_req, retire, pc); end
      end
    end
    apply_reset();
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_clear got %b expected 0", halt); end
    tick(1'b1, 1'b0);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 10'd0}) begin failures++;
      $display("FAIL halt_refetch got req=%b addr=%h expected 1 000", mem_req, mem_addr); end
  endtask

  task automatic test_reset_midtransfer();
    mem_clear();
    mem[0] = enc_i(8, 0, 5, 'h55);
    mem[1] = enc_i('h2B, 0, 5, 'h800);
    mem[2] = HALT_WORD;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      tick(c <= 7, 1'b0);
      if (c >= 8) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd512, 32'h55}) begin failures++;
          $display("FAIL sw_hold c=%0d got req=%b we=%b addr=%h wd=%h expected 1 1 200 55",
                   c, mem_req, mem_we, mem_addr, mem_wdata); end
      end
    end
    tick(1'b1, 1'b1);
    checks++; if ({mem_req, mem_we, retire} !== 3'b000) begin failures++;
      $display("FAIL abandon got req/we/ret=%b expected 000", {mem_req, mem_we, retire}); end
    checks++; if (mem[512] !== 32'h0) begin failures++; $display("FAIL abandon_mem got %h expected 0", mem[512]); end
    tick(1'b1, 1'b0);
    checks++; if ({mem_req, mem_addr, pc} !== {1'b1, 10'd0, 32'h0}) begin failures++;
      $display("FAIL abandon_refetch got req=%b addr=%h pc=%h expected 1 000 0", mem_req, mem_addr, pc); end
    for (int c = 2; c <= 9; c++) tick(1'b1, 1'b0);
    checks++; if (mem[512] !== 32'h55) begin failures++; $display("FAIL rerun_sw got %h expected 55", mem[512]); end
  endtask

  task automatic test_jump();
    mem_clear();
    mem[0]  = 32'h0800_0010;
    mem[16] = HALT_WORD;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick(1'b1, 1'b0);
`ifdef CPU_JUMP_EN
      if (c == 3) begin
        checks++; if ({retire, pc} !== {1'b1, 32'h0}) begin failures++;
          $display("FAIL j_retire got retire=%b pc=%h expected 1 0", retire, pc); end
      end
      if (c == 4) begin
        checks++; if ({mem_req, mem_addr} !== {1'b1, 10'h010}) begin failures++;
          $display("FAIL j_target got req=%b addr=%h expected 1 010", mem_req, mem_addr); end
      end
`else
      if (c >= 3) begin
        checks++; if ({halt, pc, mem_req} !== {1'b1, 32'h0, 1'b0}) begin failures++;
          $display("FAIL j_halt got halt=%b pc=%h req=%b expected 1 0 0", halt, pc, mem_req); end
      end
`endif
    end
  endtask

  task automatic gen_program(input int n);
    int kind, fsel, sh;
    logic [5:0] fn;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: mem[i] = enc_i(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
        2: mem[i] = enc_i('h23, 0, $urandom_range(0, 7), 'h800 + $urandom_range(0, 255));
        3: mem[i] = enc_i('h2B, 0, $urandom_range(0, 7), 'h800 + $urandom_range(0, 255));
        4: mem[i] = enc_i(4, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          fsel = $urandom_range(0, 5);
          case (fsel)
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
            3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'h00;
          endcase
          sh = (fn == 6'h00) ? $urandom_range(0, 31) : 0;
          mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), sh, fn);
        end
      endcase
    end
    for (int i = n; i < n + 5; i++) mem[i] = HALT_WORD;
  endtask

  task automatic test_random(input int wait_pct, input int n);
    int cyc, waits, exp_cyc;
    bit done;
    logic [31:0] cur, addr;
    gen_program(n);
    model_reset();
    apply_reset();
    cyc = 0; waits = 0; done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      tick($urandom_range(0, 99) >= wait_pct, 1'b0);
      cyc++;
      if (mem_req && !mem_ready) waits++;
      cur = m_mem[m_pc[ADDR_W+1:2]];
      if (halt) begin
        done = 1;
        checks++; if ((pc !== m_pc) || (model_legal(cur) !== 1'b0) || (cyc != 3 + waits)) begin failures++;
          $display("FAIL rnd_halt got pc=%h after %0d cycles expected pc=%h (illegal=%0d) after %0d",
                   pc, cyc, m_pc, !model_legal(cur), 3 + waits); end
      end else begin
        if (mem_req && mem_we && mem_ready) begin
          addr = m_reg[cur[25:21]] + {{16{cur[15]}}, cur[15:0]};
          checks++;
          if ((cur[31:26] !== 6'h2B) || (mem_addr !== addr[ADDR_W+1:2]) || (mem_wdata !== m_reg[cur[20:16]])) begin
            failures++;
            $display("FAIL rnd_store got addr=%h data=%h expected addr=%h data=%h (insn %h)",
                     mem_addr, mem_wdata, addr[ADDR_W+1:2], m_reg[cur[20:16]], cur); end
        end
        if (retire) begin
          exp_cyc = base_cycles(cur) + waits;
          checks++;
          if ((pc !== m_pc) || (cyc != exp_cyc)) begin failures++;
            $display("FAIL rnd_retire got pc=%h cycles=%0d expected pc=%h cycles=%0d (insn %h)",
                     pc, cyc, m_pc, exp_cyc, cur); end
          model_step();
          cyc = 0; waits = 0;
        end
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL rnd_timeout got no halt expected halt"); end
    for (int w = 512; w < 576; w++) begin
      checks++; if (mem[w] !== m_mem[w]) begin failures++;
        $display("FAIL rnd_mem word %0d got %h expected %h", w, mem[w], m_mem[w]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_clear();
    test_reset();
    test_alu_store();
    test_lw_stall();
    test_branch();
    test_halt();
    test_reset_midtransfer();
    test_jump();
    test_random(0, 40);
    test_random(35, 40);
    test_random(60, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle MIPS-subset core, successor to the single-cycle CPU. One FSM steps each instruction through fetch, decode, execute, memory and writeback. It shares one ALU and one unified instruction/data memory port, driven through a req/ready handshake. It replaces the internal instruction and data memories, so the core sits directly on an external memory or arbiter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- ADDR_W, 10: word-address width of the memory port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write (SW), 0 = read (fetch or LW).
- mem_addr  out  ADDR_W  word address, equal to byte_addr[ADDR_W+1:2].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  transfer completes on an edge where mem_req&&mem_ready.
- pc  out  32  byte address of the current instruction.
- retire  out  1  one-cycle pulse when an instruction completes.
- halt  out  1  sticky; set on an unsupported instruction.

## Operation
- States:
  - FETCH: mem_req=1, mem_addr=pc word. On ready: IR<=mem_rdata, go to DECODE.
  - DECODE: A<=reg[rs], B<=reg[rt]; decode opcode/funct. Unsupported opcode or funct: go to HALT. Otherwise go to EXEC.
  - EXEC:
    - R-type and ADDI: ALUOut<=result, go to WB.
    - LW/SW: ALUOut<=A+sext(imm), go to MEM.
    - BEQ: if A==B then pc<=pc+4+(sext(imm)<<2), else pc<=pc+4. Retire, go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut word, mem_we=(SW), mem_wdata=B. On ready:
    - LW: MDR<=mem_rdata, go to WB.
    - SW: pc<=pc+4, retire, go to FETCH.
  - WB: write rd (R-type), rt (ADDI) or rt<=MDR (LW). pc<=pc+4, retire, go to FETCH.
  - HALT: terminal; only reset leaves it.
- Opcodes: 0x00 R-type, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ.
- R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll (rt<<shamt).
- 32-bit wrap-around arithmetic; no overflow exceptions.
- imm is sign-extended 16-to-32.
- Register file: 32x32. $0 always reads 0; writes to $0 are discarded.
- Byte address low two bits are dropped on mem_addr; no alignment trap.

## Timing
- Cycle counts with zero wait states (mem_ready tied 1): BEQ 3, R/ADDI 4, SW 4, LW 5. Each wait cycle adds 1 cycle per transfer.
- mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the completing edge.
- mem_req is 0 in DECODE, EXEC, WB and HALT.
- mem_ready is ignored when mem_req=0. The bench may assert mem_ready combinationally in the same cycle as mem_req.
- retire is high for exactly one cycle, coincident with the edge that commits pc.
- Reset values: state FETCH, pc=RESET_PC, all registers 0, mem_we=0, mem_wdata=0, retire=0, halt=0. mem_req=1 during the first cycle after reset deasserts, with mem_addr=RESET_PC[ADDR_W+1:2]; mem_req=0 while reset is high.
- Reset mid-transfer: the transfer is abandoned. No register or pc update from it, no retire.
- The memory may see a truncated request; the handshake imposes no completion obligation after reset.
- halt asserts the cycle after DECODE of the illegal word. pc holds the illegal instruction's address.

## Configuration
- CPU_JUMP_EN defined: opcode 0x02 (J) is legal.
  - EXEC: pc<=(pc+4)[31:28]:target26:2'b00, retire, go to FETCH. Takes 3 cycles.
- CPU_JUMP_EN undefined: opcode 0x02 is unsupported and halts.

## Test plan
- Reset release, RESET_PC=0x40, ready tied 1 -> cycle 1 after reset: mem_req=1, mem_we=0, mem_addr=0x10.
- Program ADDI $1,$0,5; ADDI $2,$0,-7; ADD $3,$1,$2; SW $3,8($0) -> write with mem_addr=2, mem_wdata=0xFFFFFFFE. 4 retire pulses; SW completes 16 cycles after reset.
- LW $4,0($0) with mem_ready held low 3 cycles in the MEM phase -> request signals stable throughout. A following SW $4,4($0) writes the loaded value; LW takes 8 cycles.
- BEQ $0,$0,-1 at 0x20 -> next fetch at 0x20, retire every 3 cycles. BEQ $1,$2 with unequal registers -> next fetch at pc+4.
- Word 0xFC000000 -> halt=1, pc unchanged, mem_req stays 0. Reset then clears halt and refetches RESET_PC.
- J 0x0000010 at 0x0 -> with CPU_JUMP_EN: next fetch mem_addr=0x10. Without CPU_JUMP_EN: halt=1.
